// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph table and capture FSM types.
// Glyphs are active-low, bit0=a .. bit6=g.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0 = 7'b1000000;
  localparam seg7_t SEG_1 = 7'b1111001;
  localparam seg7_t SEG_2 = 7'b0100100;
  localparam seg7_t SEG_3 = 7'b0110000;
  localparam seg7_t SEG_4 = 7'b0011001;
  localparam seg7_t SEG_5 = 7'b0010010;
  localparam seg7_t SEG_6 = 7'b0000010;
  localparam seg7_t SEG_7 = 7'b1111000;
  localparam seg7_t SEG_8 = 7'b0000000;
  localparam seg7_t SEG_9 = 7'b0011000;
  localparam seg7_t SEG_A = 7'b0001000;
  localparam seg7_t SEG_B = 7'b0000011;
  localparam seg7_t SEG_C = 7'b1000110;
  localparam seg7_t SEG_D = 7'b0100001;
  localparam seg7_t SEG_E = 7'b0000110;
  localparam seg7_t SEG_F = 7'b0001110;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the glyph table: pattern -> nibble.
// Any pattern outside the sixteen glyphs (including all-off) is illegal.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  seg7_t      seg_i,
  output logic [3:0] nib_o,
  output logic       legal_o
);

  always_comb begin
    nib_o   = 4'h0;
    legal_o = 1'b1;
    case (seg_i)
      SEG_0: nib_o = 4'h0;
      SEG_1: nib_o = 4'h1;
      SEG_2: nib_o = 4'h2;
      SEG_3: nib_o = 4'h3;
      SEG_4: nib_o = 4'h4;
      SEG_5: nib_o = 4'h5;
      SEG_6: nib_o = 4'h6;
      SEG_7: nib_o = 4'h7;
      SEG_8: nib_o = 4'h8;
      SEG_9: nib_o = 4'h9;
      SEG_A: nib_o = 4'hA;
      SEG_B: nib_o = 4'hB;
      SEG_C: nib_o = 4'hC;
      SEG_D: nib_o = 4'hD;
      SEG_E: nib_o = 4'hE;
      SEG_F: nib_o = 4'hF;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Recovers hex digits from a multiplexed active-low 7-seg bus.
// Each digit's pattern must be stable STABLE_CYCLES samples to capture.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter  int NDIG          = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   dig_en,
  output logic [4*NDIG-1:0] hex,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   err,
  output logic              upd,
  output logic [IW-1:0]     upd_idx,
  output logic              frame
);

  seg7_t           seg_q;
  logic [NDIG-1:0] dig_q;
  seg7_t           ref_seg_q;
  logic [NDIG-1:0] ref_dig_q;
  logic [CW-1:0]   cnt_q;
  logic [NDIG-1:0] seen_q;
  state_e          state_q;

  logic            sel_ok;
  logic            same;
  logic            last;
  logic [IW-1:0]   idx;
  logic [3:0]      nib;
  logic            legal;
  logic [NDIG-1:0] seen_d;

  assign sel_ok = $onehot(dig_q);
  assign same   = (seg_q == ref_seg_q) && (dig_q == ref_dig_q);
  assign last   = (cnt_q == CW'(STABLE_CYCLES - 1));
  assign seen_d = seen_q | dig_q;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++)
      if (dig_q[i]) idx = IW'(i);
  end

  seg7_to_hex u_dec (
    .seg_i   (seg_q),
    .nib_o   (nib),
    .legal_o (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q     <= '0;
      dig_q     <= '0;
      ref_seg_q <= '0;
      ref_dig_q <= '0;
      cnt_q     <= '0;
      seen_q    <= '0;
      state_q   <= IDLE;
      hex       <= '0;
      valid     <= '0;
      err       <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
      frame     <= 1'b0;
    end else begin
      seg_q <= seg;
      dig_q <= dig_en;
      upd   <= 1'b0;
      frame <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sel_ok) begin
            ref_seg_q <= seg_q;
            ref_dig_q <= dig_q;
            cnt_q     <= CW'(1);
            state_q   <= TRACK;
          end
        end
        TRACK: begin
          if (!sel_ok) begin
            state_q <= IDLE;
          end else if (!same) begin
            ref_seg_q <= seg_q;
            ref_dig_q <= dig_q;
            cnt_q     <= CW'(1);
          end else begin
            if (cnt_q < CW'(STABLE_CYCLES))
              cnt_q <= cnt_q + CW'(1);
            if (last) begin
              state_q <= HOLD;
              upd     <= 1'b1;
              upd_idx <= idx;
              if (legal) begin
                hex[4*idx +: 4] <= nib;
                valid[idx]      <= 1'b1;
                err[idx]        <= 1'b0;
              end else begin
                valid[idx] <= 1'b0;
                err[idx]   <= 1'b1;
              end
              // Frame completes on the capture that fills the seen mask
              if (&seen_d) begin
                frame  <= 1'b1;
                seen_q <= '0;
              end else begin
                seen_q <= seen_d;
              end
            end
          end
        end
        HOLD: begin
          if (!sel_ok) begin
            state_q <= IDLE;
          end else if (!same) begin
            ref_seg_q <= seg_q;
            ref_dig_q <= dig_q;
            cnt_q     <= CW'(1);
            state_q   <= TRACK;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed-vector bench for seg7_capture (NDIG=4, STABLE_CYCLES=4).
// Expected values are hand-derived from the glyph table and capture timing.
module tb_seg7_capture;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] hex;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        frame;

  int n_cmp = 0;
  int n_bad = 0;

  int upd_n;
  int upd_at;
  int frm_n;
  int frm_at;
  int last_idx;

  always #5 clk = ~clk;

  seg7_capture #(.NDIG(4), .STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .dig_en  (dig_en),
    .hex     (hex),
    .valid   (valid),
    .err     (err),
    .upd     (upd),
    .upd_idx (upd_idx),
    .frame   (frame)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Apply a sample for n clocks, logging upd/frame pulses by tick number.
  task automatic drive(input logic [6:0] s, input logic [3:0] d,
                       input int n);
    seg      = s;
    dig_en   = d;
    upd_n    = 0;
    upd_at   = 0;
    frm_n    = 0;
    frm_at   = 0;
    last_idx = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (upd === 1'b1) begin
        upd_n++;
        if (upd_at == 0) upd_at = i;
        last_idx = int'(upd_idx);
      end
      if (frame === 1'b1) begin
        frm_n++;
        frm_at = i;
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    seg    = 7'h7F;
    dig_en = 4'b0000;
    #12;
    chk("rst_hex",   32'(hex),   32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err",   32'(err),   32'h0);
    chk("rst_upd",   32'(upd),   32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Stable '2' on digit 0
    drive(SEG_2, 4'b0001, 8);
    chk("d0_updn",  upd_n,         1);
    chk("d0_updat", upd_at,        5);
    chk("d0_idx",   last_idx,      0);
    chk("d0_hex",   32'(hex[3:0]), 32'h2);
    chk("d0_valid", 32'(valid),    32'h1);
    chk("d0_frm",   frm_n,         0);

    // Glitched '8' never settles, then '9' on digit 1
    drive(SEG_8, 4'b0010, 3);
    chk("g8_updn", upd_n, 0);
    drive(SEG_9, 4'b0010, 8);
    chk("d1_updn",  upd_n,         1);
    chk("d1_updat", upd_at,        5);
    chk("d1_idx",   last_idx,      1);
    chk("d1_hex",   32'(hex[7:4]), 32'h9);
    chk("d1_valid", 32'(valid),    32'h3);

    // '5' on digit 2, then illegal all-off
    drive(SEG_5, 4'b0100, 6);
    chk("d2_hex5", 32'(hex[11:8]), 32'h5);
    drive(7'h7F, 4'b0100, 6);
    chk("ill_updn",  upd_n,          1);
    chk("ill_idx",   last_idx,       2);
    chk("ill_err",   32'(err),       32'h4);
    chk("ill_valid", 32'(valid),     32'h3);
    chk("ill_hex",   32'(hex[11:8]), 32'h5);
    chk("ill_frm",   frm_n,          0);

    // Non-one-hot enables never capture
    drive(SEG_A, 4'b0011, 10);
    chk("twohot_updn", upd_n, 0);
    drive(SEG_A, 4'b0000, 10);
    chk("zerohot_updn", upd_n, 0);

    // A,B,C,D on digits 0..3; digit 3 completes the frame
    drive(SEG_A, 4'b0001, 6);
    chk("fa_frm", frm_n, 0);
    drive(SEG_B, 4'b0010, 6);
    chk("fb_frm", frm_n, 0);
    drive(SEG_C, 4'b0100, 6);
    chk("fc_frm", frm_n, 0);
    chk("fc_err", 32'(err), 32'h0);
    drive(SEG_D, 4'b1000, 6);
    chk("fd_updn",  upd_n,       1);
    chk("fd_frmn",  frm_n,       1);
    chk("fd_frmat", frm_at,      upd_at);
    chk("fd_idx",   last_idx,    3);
    chk("f_hex",    32'(hex),    32'hDCBA);
    chk("f_valid",  32'(valid),  32'hF);

    drive(SEG_E, 4'b0001, 6);
    chk("re_updn", upd_n,         1);
    chk("re_frm",  frm_n,         0);
    chk("re_hex",  32'(hex[3:0]), 32'hE);

    // Reset while tracking at cnt=3
    drive(SEG_1, 4'b0001, 4);
    chk("pre_rst_upd", upd_n, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_hex",   32'(hex),     32'h0);
    chk("ar_valid", 32'(valid),   32'h0);
    chk("ar_err",   32'(err),     32'h0);
    chk("ar_upd",   32'(upd),     32'h0);
    chk("ar_idx",   32'(upd_idx), 32'h0);
    chk("ar_frame", 32'(frame),   32'h0);
    #1;
    rst = 1'b0;
    drive(SEG_1, 4'b0001, 8);
    chk("pr_updn",  upd_n,         1);
    chk("pr_updat", upd_at,        5);
    chk("pr_hex",   32'(hex[3:0]), 32'h1);
    chk("pr_valid", 32'(valid),    32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
